mem_load_unit: RTL and testbench
================================

// Module: mem_load_unit
// PURPOSE
//  Load-side memory access stage of mips_cpu. Accepts one load request from the execute stage and performs a
//  single Avalon-style word read, holding it through waitrequest. Returns the extracted, sign/zero-extended
//  result for LB/LBU/LH/LHU/LW. For LWL/LWR it returns the raw aligned word plus byte_number (3'b001..3'b100),
//  which the downstream LWL/LWR merge stage consumes as SrcA. One request outstanding at a time; busy stalls the pipeline.
// PARAMETERS
//  MAX_WAIT  default 255  waitrequest cycles tolerated before read is aborted with rsp_err (1..65535)
// PORTS
//  clk              in   1   single clock, rising edge
//  reset_n          in   1   asynchronous, active-low reset
//  req_valid        in   1   load request present
//  req_ready        out  1   unit can accept request (IDLE only)
//  req_op           in   3   000 LB,001 LBU,010 LH,011 LHU,100 LW,101 LWL,110 LWR,111 illegal
//  req_addr         in   32  byte address
//  req_rt           in   5   destination register tag, passed through
//  avm_address      out  32  word-aligned address {addr[31:2],2'b00}
//  avm_read         out  1   read strobe
//  avm_byteenable   out  4   byte lanes, little-endian (lane k = bits 8k+7:8k)
//  avm_waitrequest  in   1   slave stall
//  avm_readdata     in   32  read data, valid when avm_read=1 and avm_waitrequest=0
//  rsp_valid        out  1   response present
//  rsp_ready        in   1   downstream accepts response
//  rsp_data         out  32  extended result (LB..LW) or raw word (LWL/LWR); 0 when rsp_err
//  rsp_byte_number  out  3   addr[1:0]+1 (001..100); 000 for non-LWL/LWR ops
//  rsp_merge        out  1   1 for LWL/LWR, meaning rsp_data goes to the merge stage
//  rsp_op           out  3   registered req_op
//  rsp_rt           out  5   registered req_rt
//  rsp_err          out  1   misaligned LH/LHU/LW, illegal op, or timeout
//  busy             out  1   state != IDLE
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE. All outputs 0 except req_ready=1. Wait counter = 0.
//  Reset mid-read drops the bus transaction immediately (avm_read=0). No response is produced.
//  States: IDLE, READ, RESP. All outputs are registered.
//  IDLE: req_ready=1. On req_valid, latch op/addr/rt.
//   - Fault (LH/LHU with addr[0]=1, LW with addr[1:0]!=0, op=111): go to RESP with rsp_err=1. No bus access.
//   - Otherwise go to READ. avm_read=1 from the next cycle.
//   - Byteenable: LB/LBU 1<<addr[1:0]; LH/LHU addr[1]?1100:0011; LW/LWL/LWR 1111.
//  READ: avm_address/avm_byteenable/avm_read are held stable while avm_waitrequest=1, and the counter increments.
//   - waitrequest=0: capture readdata, drop avm_read next cycle, go to RESP.
//   - Counter reaches MAX_WAIT with waitrequest still 1: drop avm_read, go to RESP with rsp_err=1, rsp_data=0.
//   - Counter clears on entering READ.
//  RESP: rsp_valid=1. All rsp_* are held stable until rsp_ready=1, then go to IDLE the next cycle.
//   - req_ready stays 0 in the cycle rsp is consumed, so there is no back-to-back acceptance in that cycle.
//  Extraction, with w = captured word, b = addr[1:0]:
//   - LB: sext(w[8b+7:8b]). LBU: zext of the same byte.
//   - LH: sext(w[16*addr[1]+15 : 16*addr[1]]). LHU: zext of the same half.
//   - LW: w.
//   - LWL/LWR: rsp_data = w, rsp_byte_number = b+1, rsp_merge = 1.
//  Latency: accept at cycle 0; avm_read=1 at cycle 1. With waitrequest=0 at cycle 1, rsp_valid=1 at cycle 2.
//   - Each waitrequest cycle adds one cycle. A fault gives rsp_valid at cycle 1.
//  req_valid is ignored outside IDLE. avm_readdata is ignored outside READ.
// TESTING
//  1 LW addr 0x100, waitrequest=0, readdata 0xDEADBEEF -> avm_address 0x100, be 1111;
//    rsp_valid at cycle 2, rsp_data 0xDEADBEEF, err 0.
//  2 LB addr 0x103, readdata 0x80112233 -> be 1000, rsp_data 0xFFFFFF80. LBU same -> 0x00000080.
//  3 LWR addr 0x202, 3 waitrequest cycles, readdata 0x11223344 -> address held 0x200 for 4 cycles;
//    rsp_data 0x11223344, byte_number 011, merge 1, rsp_valid at cycle 5.
//  4 LH addr 0x101 -> no avm_read ever; rsp_valid cycle 1, rsp_err 1, rsp_data 0. Same for op=111.
//  5 MAX_WAIT=4, waitrequest held 1 -> avm_read drops after 4 cycles; rsp_err 1; then IDLE with req_ready 1.
//  6 rsp_ready=0 for 3 cycles -> rsp_* stable, req_valid ignored.
//    Also: reset_n low during READ -> avm_read 0 immediately, no rsp_valid after release.

Source files
------------

// File: rtl/mem_load_unit.sv
// Load-side memory access stage: one Avalon word read per request, with byte/half
// extraction and sign/zero extension, or raw word plus byte_number for LWL/LWR merging.
module mem_load_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [4:0]  req_rt,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_byte_number,
    output logic        rsp_merge,
    output logic [2:0]  rsp_op,
    output logic [4:0]  rsp_rt,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_LWL = 3'b101;
    localparam logic [2:0] OP_LWR = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic [1:0]  lane, lane_nxt;
    logic [31:0] avm_address_nxt, rsp_data_nxt;
    logic [3:0]  avm_byteenable_nxt;
    logic [2:0]  rsp_byte_number_nxt, rsp_op_nxt;
    logic        rsp_merge_nxt, rsp_err_nxt;
    logic [4:0]  rsp_rt_nxt;
    logic        fault, merge;

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] b,
                                            input logic [31:0] w);
        logic [7:0]  byt;
        logic [15:0] half;
        byt  = w[{b, 3'b000} +: 8];
        half = b[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   extract = {{24{byt[7]}}, byt};
            OP_LBU:  extract = {24'd0, byt};
            OP_LH:   extract = {{16{half[15]}}, half};
            OP_LHU:  extract = {16'd0, half};
            default: extract = w;
        endcase
    endfunction

    assign req_ready = (state == IDLE);
    assign avm_read  = (state == READ);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    assign merge = (req_op == OP_LWL) || (req_op == OP_LWR);
    assign fault = (((req_op == OP_LH) || (req_op == OP_LHU)) && req_addr[0])
                 || ((req_op == OP_LW) && (req_addr[1:0] != 2'b00))
                 || (req_op == OP_ILL);

    always_comb begin
        state_nxt           = state;
        wait_cnt_nxt        = wait_cnt;
        lane_nxt            = lane;
        avm_address_nxt     = avm_address;
        avm_byteenable_nxt  = avm_byteenable;
        rsp_data_nxt        = rsp_data;
        rsp_byte_number_nxt = rsp_byte_number;
        rsp_merge_nxt       = rsp_merge;
        rsp_op_nxt          = rsp_op;
        rsp_rt_nxt          = rsp_rt;
        rsp_err_nxt         = rsp_err;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    lane_nxt            = req_addr[1:0];
                    avm_address_nxt     = {req_addr[31:2], 2'b00};
                    rsp_op_nxt          = req_op;
                    rsp_rt_nxt          = req_rt;
                    rsp_data_nxt        = '0;
                    rsp_merge_nxt       = merge;
                    rsp_byte_number_nxt = merge ? ({1'b0, req_addr[1:0]} + 3'd1) : 3'd0;
                    rsp_err_nxt         = fault;
                    wait_cnt_nxt        = '0;
                    case (req_op)
                        OP_LB, OP_LBU: avm_byteenable_nxt = 4'b0001 << req_addr[1:0];
                        OP_LH, OP_LHU: avm_byteenable_nxt = req_addr[1] ? 4'b1100 : 4'b0011;
                        default:       avm_byteenable_nxt = 4'b1111;
                    endcase
                    state_nxt = fault ? RESP : READ;
                end
            end
            READ: begin
                if (!avm_waitrequest) begin
                    rsp_data_nxt = extract(rsp_op, lane, avm_readdata);
                    state_nxt    = RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    rsp_err_nxt  = 1'b1;
                    rsp_data_nxt = '0;
                    state_nxt    = RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            lane            <= '0;
            avm_address     <= '0;
            avm_byteenable  <= '0;
            rsp_data        <= '0;
            rsp_byte_number <= '0;
            rsp_merge       <= 1'b0;
            rsp_op          <= '0;
            rsp_rt          <= '0;
            rsp_err         <= 1'b0;
        end else begin
            state           <= state_nxt;
            wait_cnt        <= wait_cnt_nxt;
            lane            <= lane_nxt;
            avm_address     <= avm_address_nxt;
            avm_byteenable  <= avm_byteenable_nxt;
            rsp_data        <= rsp_data_nxt;
            rsp_byte_number <= rsp_byte_number_nxt;
            rsp_merge       <= rsp_merge_nxt;
            rsp_op          <= rsp_op_nxt;
            rsp_rt          <= rsp_rt_nxt;
            rsp_err         <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit: Avalon responder with per-request wait states,
// response monitor comparing against queued expectations including latency.
module tb_mem_load_unit;

    localparam int unsigned MAXW = 4;

    logic        clk, reset_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [4:0]  req_rt;
    logic [31:0] avm_address, avm_readdata;
    logic        avm_read, avm_waitrequest;
    logic [3:0]  avm_byteenable;
    logic        rsp_valid, rsp_ready, rsp_merge, rsp_err, busy;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_byte_number, rsp_op;
    logic [4:0]  rsp_rt;

    mem_load_unit #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_rt(req_rt),
        .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_byte_number(rsp_byte_number), .rsp_merge(rsp_merge), .rsp_op(rsp_op),
        .rsp_rt(rsp_rt), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bn;
        logic        err;
        logic [2:0]  op;
        logic [4:0]  rt;
        int          lat;
        int          t0;
    } exp_t;
    exp_t sb[$];

    logic [31:0] exp_addr = '0;
    logic [3:0]  exp_be = '0;
    int          wait_cfg = 0;
    logic [31:0] rdata_cfg = '0;
    int          reads_seen = 0;

    // Avalon slave: waitrequest for wait_cfg cycles of each read, then returns rdata_cfg
    initial begin
        int wcnt;
        wcnt = 0;
        avm_waitrequest = 1'b1;
        avm_readdata    = '0;
        forever begin
            @(negedge clk);
            if (avm_read) begin
                reads_seen++;
                check("avm_addr", avm_address, exp_addr);
                check("avm_be", 32'(avm_byteenable), 32'(exp_be));
                if (wcnt < wait_cfg) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = $urandom;
                    wcnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata    = rdata_cfg;
                end
            end else begin
                wcnt = 0;
                avm_waitrequest = 1'($urandom_range(0, 1));
                avm_readdata    = $urandom;
            end
        end
    end

    initial begin
        logic seen;
        int   first;
        exp_t e;
        seen  = 1'b0;
        first = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid && !seen) begin
                seen  = 1'b1;
                first = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                seen = 1'b0;
                check("rdy_in_consume", 32'(req_ready), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_bn", 32'(rsp_byte_number), 32'(e.bn));
                    check("rsp_merge", 32'(rsp_merge), 32'(e.bn != 3'd0));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_op", 32'(rsp_op), 32'(e.op));
                    check("rsp_rt", 32'(rsp_rt), 32'(e.rt));
                    check("latency", 32'(first - e.t0), 32'(e.lat));
                end
            end
        end
    end

    task automatic wait_ready();
        int budget;
        budget = 0;
        while (!req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) check("ready_wait", 32'd0, 32'd1);
    endtask

    task automatic run_one(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                           input int nwait, input logic [31:0] exp_data, input logic exp_err,
                           input logic [2:0] exp_bn, input logic [3:0] be, input logic [4:0] rt,
                           input int nhold);
        exp_t e;
        logic flt;
        int   reads, budget;
        wait_ready();
        flt = exp_err && (nwait < int'(MAXW));
        exp_addr   = {addr[31:2], 2'b00};
        exp_be     = be;
        wait_cfg   = nwait;
        rdata_cfg  = rdata;
        reads_seen = 0;
        e.data = exp_data; e.bn = exp_bn; e.err = exp_err; e.op = op; e.rt = rt; e.t0 = cyc;
        e.lat  = flt ? 1 : (nwait >= int'(MAXW) ? 1 + int'(MAXW) : 2 + nwait);
        reads  = flt ? 0 : (nwait >= int'(MAXW) ? int'(MAXW) : nwait + 1);
        sb.push_back(e);
        if (nhold > 0) rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_rt = rt;
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_rt = 5'($urandom);
        if (nhold > 0) begin
            budget = 0;
            while (!rsp_valid && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            for (int i = 0; i < nhold; i++) begin
                req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h0000_0040; req_rt = 5'd31;
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_data", rsp_data, exp_data);
                check("hold_rt", 32'(rsp_rt), 32'(rt));
                check("hold_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        budget = 0;
        while (sb.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        check("bus_reads", 32'(reads_seen), 32'(reads));
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_rt = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_avm_read", 32'(avm_read), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_avm_addr", avm_address, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        //      op      addr          rdata         wait  exp_data      err bn    be     rt  hold
        run_one(3'b100, 32'h0000_0100, 32'hDEADBEEF, 0,    32'hDEADBEEF, 0, 3'd0, 4'hF, 5'd1, 0);
        run_one(3'b000, 32'h0000_0103, 32'h80112233, 0,    32'hFFFFFF80, 0, 3'd0, 4'h8, 5'd2, 0);
        run_one(3'b001, 32'h0000_0103, 32'h80112233, 0,    32'h00000080, 0, 3'd0, 4'h8, 5'd3, 0);
        run_one(3'b110, 32'h0000_0202, 32'h11223344, 3,    32'h11223344, 0, 3'd3, 4'hF, 5'd4, 0);
        run_one(3'b010, 32'h0000_0101, 32'h12345678, 0,    32'h00000000, 1, 3'd0, 4'h0, 5'd5, 0);
        run_one(3'b111, 32'h0000_0100, 32'h12345678, 0,    32'h00000000, 1, 3'd0, 4'h0, 5'd6, 0);
        run_one(3'b100, 32'h0000_0300, 32'h55555555, 1000, 32'h00000000, 1, 3'd0, 4'hF, 5'd7, 0);
        @(negedge clk);
        check("idle_after_timeout", 32'(req_ready), 32'd1);
        check("busy_after_timeout", 32'(busy), 32'd0);
        run_one(3'b010, 32'h0000_0102, 32'h80017FFF, 0,    32'hFFFF8001, 0, 3'd0, 4'hC, 5'd8, 0);
        run_one(3'b011, 32'h0000_0100, 32'h8001F00F, 2,    32'h0000F00F, 0, 3'd0, 4'h3, 5'd9, 0);
        run_one(3'b101, 32'h0000_0105, 32'hCAFEF00D, 1,    32'hCAFEF00D, 0, 3'd2, 4'hF, 5'd10, 0);
        run_one(3'b000, 32'h0000_0001, 32'h00007F00, 0,    32'h0000007F, 0, 3'd0, 4'h2, 5'd11, 0);
        run_one(3'b100, 32'h0000_0102, 32'h00000000, 0,    32'h00000000, 1, 3'd0, 4'h0, 5'd12, 0);
        run_one(3'b001, 32'h0000_0000, 32'hFFFFFFA5, 0,    32'h000000A5, 0, 3'd0, 4'h1, 5'd13, 0);
        run_one(3'b010, 32'h0000_0100, 32'h12348765, 1,    32'hFFFF8765, 0, 3'd0, 4'h3, 5'd14, 0);
        run_one(3'b110, 32'h0000_0203, 32'h99999999, 1000, 32'h00000000, 1, 3'd4, 4'hF, 5'd15, 0);
        run_one(3'b011, 32'h0000_0103, 32'h00000000, 0,    32'h00000000, 1, 3'd0, 4'h0, 5'd16, 0);
        run_one(3'b100, 32'h0000_0500, 32'h5A5A1234, 0,    32'h5A5A1234, 0, 3'd0, 4'hF, 5'd17, 3);

        // Reset in the middle of a stalled read: bus drops at once, no response afterwards
        wait_ready();
        exp_addr = 32'h0000_0400; exp_be = 4'hF; wait_cfg = 1000;
        req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h0000_0400; req_rt = 5'd20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_read", 32'(avm_read), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_avm_read", 32'(avm_read), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check("no_rsp_after_rst", 32'(cnt), 32'd0);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
